tl_state_ctrl: RTL and testbench
================================

# tl_state_ctrl

State-sequencing stage of the traffic light controller with left-turn phases. It holds the 3-bit phase register and a dwell counter, and advances the phase from sensor inputs and a time-base tick. Its `state` output is the sole input of the downstream output-decode stage, which maps `state` to the `La`/`Lb` light codes.

## Interface
Parameters:
- `YEL_TICKS`, default 5: ticks spent in each yellow phase. Legal range is ≥1.
- `MIN_GO_TICKS`, default 3: minimum ticks spent in each green or left phase. Legal range is ≥1.
- `CNT_W`, default 4: dwell counter width. Must hold max(`YEL_TICKS`, `MIN_GO_TICKS`).

Ports:
- `clk`, input, 1: system clock. Rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `tick`, input, 1: time-base enable, one cycle wide. Only ticks advance dwell time.
- `ta`, input, 1: traffic present on street A, straight.
- `tal`, input, 1: traffic present on street A, left turn.
- `tb`, input, 1: traffic present on street B, straight.
- `tbl`, input, 1: traffic present on street B, left turn.
- `state`, output, 3: current phase. Registered. Drives the output-decode stage.
- `state_chg`, output, 1: registered pulse. High for exactly the first cycle in which `state` holds a new value.

## Operation
Phases, in fixed cyclic order (light codes: red=00, yellow=01, green=10, left=11):
- `S0=000` A green. `S1=001` A yellow. `S2=010` A left. `S3=011` A yellow.
- `S4=100` B green. `S5=101` B yellow. `S6=110` B left. `S7=111` B yellow.
- Street B is red in S0–S3. Street A is red in S4–S7.

"Go" phases (S0, S2, S4, S6; `state[0]=0`):
- Hold sensors: `ta` for S0, `tal` for S2, `tb` for S4, `tbl` for S6.
- The phase exits at an edge where all of the following hold: `tick=1`, `cnt+1 >= MIN_GO_TICKS`, and the hold sensor is 0.
- If the hold sensor is 1, the phase holds indefinitely, even after the minimum time has elapsed.

Yellow phases (S1, S3, S5, S7; `state[0]=1`):
- The phase exits at an edge with `tick=1` and `cnt+1 == YEL_TICKS`.
- Sensors are ignored.

Next state is always `state+1` modulo 8 (S7 wraps to S0). No phase is skipped.

Dwell counter `cnt`:
- Cleared to 0 on every phase transition.
- Otherwise increments on `tick`, saturating at 2^`CNT_W`−1. Saturation only matters in held go phases.

`state_chg` is 1 in the cycle after the edge that changed `state`, and 0 otherwise.

Reset (sync, active-high, dominant over all other inputs):
- `state=000`, `cnt=0`, `state_chg=0` at the next edge.
- `tick` and sensors are ignored while `reset=1`.
- Reset mid-phase abandons the current phase immediately. No yellow is inserted.
- The first cycle after reset release is S0 with `cnt=0`. `state_chg` stays 0, since reset is not a transition.

## Timing
- One transition per edge maximum. Exit evaluation uses `cnt` and the sensors sampled at that edge.
- Latency from the qualifying tick edge to the new `state`: 0 cycles. `state` updates on that edge.
- Yellow phase duration: exactly `YEL_TICKS` ticks.
- Go phase duration: max(`MIN_GO_TICKS`, ticks until the hold sensor drops) ticks.
- Minimum full cycle: 4·`MIN_GO_TICKS` + 4·`YEL_TICKS` ticks.
- A sensor edge with `tick=0` has no effect until the next tick.

## Structure
- Shared header `tl_defs.vh` contains:
  - phase constants `S0`..`S7`;
  - light codes `L_RED`, `L_YEL`, `L_GRN`, `L_LEFT`.
- The output-decode stage includes the same header.
- Sub-module `tl_dwell_cnt`: saturating counter with ports clk, reset, clr, en, cnt.
- The top level holds the state register, exit comparison and `state_chg` flop.

## Test plan
All scenarios use `YEL_TICKS=3`, `MIN_GO_TICKS=2`.

1. Reset: assert `reset` 2 cycles with `tick=1` and all sensors 1 → `state=000`, `state_chg=0`. S0 is held after release.
2. Hold: `ta=1` for 10 ticks in S0 → `state` stays 000. Drop `ta` → next tick edge gives `state=001`, with `state_chg=1` for one cycle.
3. Yellow with sparse tick: `tick` every 4th cycle in S1 → S2 entered exactly at the 3rd tick, i.e. 12 cycles after S1 entry.
4. Minimum go: `tal=0` from S2 entry, `tick` every cycle → S2 lasts exactly 2 cycles. `tal` pulsed high only with `tick=0` → no extension.
5. Full loop: all sensors 0, `tick` every cycle → sequence 000→001→…→111→000 in 20 cycles, with 8 `state_chg` pulses.
6. Mid-phase reset: assert `reset` in S5 at `cnt=1` → next edge `state=000`, `cnt=0`. After release, S0 persists for 2 ticks minimum.

Source files
------------

// File: rtl/tl_state_ctrl_pkg.sv
// Shared definitions for the traffic light controller: phase encoding,
// light codes and small helpers used by the sequencing and decode stages.
package tl_state_ctrl_pkg;

  // Phases in fixed cyclic order; bit 0 set marks a yellow phase.
  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow
    S2 = 3'b010,  // A left
    S3 = 3'b011,  // A yellow
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow
    S6 = 3'b110,  // B left
    S7 = 3'b111   // B yellow
  } phase_t;

  // Light codes driven by the output-decode stage.
  localparam logic [1:0] L_RED  = 2'b00;
  localparam logic [1:0] L_YEL  = 2'b01;
  localparam logic [1:0] L_GRN  = 2'b10;
  localparam logic [1:0] L_LEFT = 2'b11;

  // Yellow phases ignore sensors and run a fixed number of ticks.
  function automatic logic is_yellow(input phase_t p);
    return p[0];
  endfunction

  // Selects the sensor that keeps the current go phase alive.
  function automatic logic hold_sensor(input phase_t p, input logic ta,
                                       input logic tal, input logic tb,
                                       input logic tbl);
    logic h;
    case (p)
      S0:      h = ta;
      S2:      h = tal;
      S4:      h = tb;
      S6:      h = tbl;
      default: h = 1'b0;
    endcase
    return h;
  endfunction

  // Street A light code for a phase (red while B owns the junction).
  function automatic logic [1:0] light_a(input phase_t p);
    logic [1:0] l;
    case (p)
      S0:           l = L_GRN;
      S2:           l = L_LEFT;
      S1, S3:       l = L_YEL;
      default:      l = L_RED;
    endcase
    return l;
  endfunction

  // Street B light code for a phase (red while A owns the junction).
  function automatic logic [1:0] light_b(input phase_t p);
    logic [1:0] l;
    case (p)
      S4:           l = L_GRN;
      S6:           l = L_LEFT;
      S5, S7:       l = L_YEL;
      default:      l = L_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_dwell_cnt.sv
// Dwell counter: counts time-base ticks within a phase, saturating at
// all-ones so a long-held go phase never wraps back below the minimum.
module tl_dwell_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Clear dominates enable; hold at the maximum value once reached.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/tl_state_ctrl.sv
// Phase sequencer: holds the phase register, decides when the current
// phase exits, and emits a one-cycle pulse on the first cycle of a phase.
// tick is a plain one-cycle enable with no handshake; sensors are levels
// sampled only on edges where tick is high.
module tl_state_ctrl
  import tl_state_ctrl_pkg::*;
#(
  parameter int YEL_TICKS    = 5,
  parameter int MIN_GO_TICKS = 3,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ta,
  input  logic       tal,
  input  logic       tb,
  input  logic       tbl,
  output logic [2:0] state,
  output logic       state_chg
);

  // Limits widened by one bit so cnt+1 at saturation does not wrap.
  localparam logic [CNT_W:0] YEL_LIM = (CNT_W+1)'(YEL_TICKS);
  localparam logic [CNT_W:0] GO_LIM  = (CNT_W+1)'(MIN_GO_TICKS);

  phase_t           cur_q;
  phase_t           nxt;
  logic             adv;
  logic             hold;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_p1;

  assign cnt_p1 = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign hold   = hold_sensor(cur_q, ta, tal, tb, tbl);

  // Exit decision and next phase; at most one step forward per edge.
  always_comb begin
    adv = 1'b0;
    nxt = cur_q;
    if (tick) begin
      if (is_yellow(cur_q)) begin
        adv = (cnt_p1 == YEL_LIM);
      end else begin
        adv = (cnt_p1 >= GO_LIM) && !hold;
      end
    end
    if (adv) begin
      nxt = phase_t'(cur_q + 3'd1);
    end
  end

  // Phase register and change pulse; reset is not counted as a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q     <= S0;
      state_chg <= 1'b0;
    end else begin
      cur_q     <= nxt;
      state_chg <= adv;
    end
  end

  tl_dwell_cnt #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .clr  (adv),
    .en   (tick),
    .cnt  (cnt)
  );

  assign state = cur_q;

endmodule

// File: tb/tb_tl_state_ctrl.sv
// Bench for tl_state_ctrl: fixed vector table, hand-written corner
// sequences and a randomized run against a tick-counting reference model.
module tb_tl_state_ctrl;

  localparam int YEL  = 3;
  localparam int MING = 2;
  localparam int CW   = 4;

  logic       clk = 1'b0;
  logic       reset, tick, ta, tal, tb, tbl;
  logic [2:0] state;
  logic       state_chg;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase number and ticks spent in it as plain integers.
  int m_phase = 0;
  int m_ticks = 0;
  bit m_chg   = 0;

  typedef struct {
    bit r, t, a, al, b, bl;
    int es;
    bit ec;
  } vec_t;

  vec_t vecs[15];

  // clock
  always #5 clk = ~clk;

  tl_state_ctrl #(
    .YEL_TICKS   (YEL),
    .MIN_GO_TICKS(MING),
    .CNT_W       (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .ta       (ta),
    .tal      (tal),
    .tb       (tb),
    .tbl      (tbl),
    .state    (state),
    .state_chg(state_chg)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One edge of the reference: even phases need MING ticks and a low
  // hold sensor, odd phases exactly YEL ticks; phases go round 0..7.
  function automatic void model_edge(bit r, bit t, bit a, bit al, bit b, bit bl);
    bit adv;
    bit hold;
    int nt;
    if (r) begin
      m_phase = 0;
      m_ticks = 0;
      m_chg   = 0;
      return;
    end
    adv = 0;
    if (t) begin
      nt = m_ticks + 1;
      if (m_phase % 2 == 1) begin
        adv = (nt == YEL);
      end else begin
        case (m_phase)
          0:       hold = a;
          2:       hold = al;
          4:       hold = b;
          default: hold = bl;
        endcase
        adv = (nt >= MING) && !hold;
      end
      if (adv) begin
        m_phase = (m_phase + 1) % 8;
        m_ticks = 0;
      end else begin
        m_ticks = nt;
      end
    end
    m_chg = adv;
  endfunction

  // Driver: apply inputs between edges, advance model, sample 1ns after.
  task automatic step(input bit r, input bit t, input bit a, input bit al,
                      input bit b, input bit bl);
    reset = r; tick = t; ta = a; tal = al; tb = b; tbl = bl;
    @(posedge clk);
    model_edge(r, t, a, al, b, bl);
    #1;
    check("model_state", int'(state), m_phase);
    check("model_chg", int'(state_chg), int'(m_chg));
  endtask

  initial begin
    int n;
    int cycles, pulses, order_bad, prev;
    bit seen7;
    bit sa, sal, sb, sbl;

    reset = 1; tick = 0; ta = 0; tal = 0; tb = 0; tbl = 0;

    // fields: r t ta tal tb tbl | state chg
    vecs[0]  = '{1, 1, 1, 1, 1, 1, 0, 0};
    vecs[1]  = '{1, 1, 1, 1, 1, 1, 0, 0};
    vecs[2]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 0, 1, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0, 1, 0};
    vecs[8]  = '{0, 1, 1, 1, 1, 1, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 2, 1};
    vecs[10] = '{0, 1, 0, 0, 0, 0, 2, 0};
    vecs[11] = '{0, 1, 0, 0, 0, 0, 3, 1};
    vecs[12] = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 1, 0, 0, 0, 0, 1, 1};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].r, vecs[i].t, vecs[i].a, vecs[i].al, vecs[i].b, vecs[i].bl);
      check($sformatf("vec%0d_state", i), int'(state), vecs[i].es);
      check($sformatf("vec%0d_chg", i), int'(state_chg), int'(vecs[i].ec));
    end

    // Hold in S0 for 10 ticks, then release.
    step(1, 1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0);
    check("hold_s0_state", int'(state), 0);
    step(0, 1, 0, 0, 0, 0);
    check("hold_exit_state", int'(state), 1);
    check("hold_exit_chg", int'(state_chg), 1);
    step(0, 0, 0, 0, 0, 0);
    check("chg_one_cycle", int'(state_chg), 0);

    // Yellow with a tick every 4th cycle; cycle 1 of S1 already done.
    n = 1;
    while (state != 3'd2 && n < 40) begin
      n++;
      step(0, (n % 4 == 0), 0, 0, 0, 0);
    end
    check("yel_sparse_cycles", n, 12);

    // Minimum go in S2, with a tal pulse only on a non-tick cycle.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("min_go_pulse_state", int'(state), 2);
    step(0, 1, 0, 0, 0, 0);
    check("min_go_exit_state", int'(state), 3);
    check("min_go_exit_chg", int'(state_chg), 1);

    // Full loop with no traffic.
    step(1, 0, 0, 0, 0, 0);
    cycles = 0; pulses = 0; order_bad = 0; prev = 0; seen7 = 0;
    while (cycles < 60) begin
      step(0, 1, 0, 0, 0, 0);
      cycles++;
      if (state_chg) pulses++;
      if (int'(state) != prev) begin
        if (int'(state) != (prev + 1) % 8) order_bad++;
        prev = int'(state);
      end
      if (state == 3'd7) seen7 = 1;
      if (seen7 && state == 3'd0) break;
    end
    check("loop_cycles", cycles, 20);
    check("loop_pulses", pulses, 8);
    check("loop_order_errs", order_bad, 0);

    // Reset in S5 with one tick already counted.
    n = 0;
    while (state != 3'd5 && n < 40) begin
      n++;
      step(0, 1, 0, 0, 0, 0);
    end
    check("reach_s5", int'(state), 5);
    step(0, 1, 0, 0, 0, 0);
    check("s5_cnt1_state", int'(state), 5);
    step(1, 1, 1, 1, 1, 1);
    check("rst_mid_state", int'(state), 0);
    check("rst_mid_chg", int'(state_chg), 0);
    step(0, 1, 0, 0, 0, 0);
    check("post_rst_tick1", int'(state), 0);
    step(0, 1, 0, 0, 0, 0);
    check("post_rst_tick2", int'(state), 1);

    // Randomized run: sticky sensors, frequent ticks, rare resets.
    sa = 0; sal = 0; sb = 0; sbl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sa  = ~sa;
      if ($urandom_range(0, 7) == 0) sal = ~sal;
      if ($urandom_range(0, 7) == 0) sb  = ~sb;
      if ($urandom_range(0, 7) == 0) sbl = ~sbl;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
           sa, sal, sb, sbl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
